// File: rtl/dot_product_accumulator.sv
// Streaming dot-product accumulator: sums every LENGTH accepted terms into one
// registered result presented on a valid/ready output while the next vector fills.
module dot_product_accumulator #(
  parameter int unsigned WIDTH     = 11,
  parameter int unsigned LENGTH    = 8,
  parameter int unsigned ACC_WIDTH = 14
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 overflow
);

  localparam int unsigned CNT_W = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int unsigned SUM_W = ((ACC_WIDTH > WIDTH) ? ACC_WIDTH : WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LENGTH - 1);

  logic [ACC_WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]     r_cnt;
  logic [ACC_WIDTH-1:0] r_out_data;
  logic                 r_out_valid;
  logic                 r_overflow;

  logic             w_last;
  logic             w_in_ready;
  logic             w_accept;
  logic [SUM_W-1:0] w_sum;
  logic             w_carry;

  // Ready depends on registered state only; only the final term stalls on a held result.
  assign w_last     = (r_cnt == LAST_CNT);
  assign w_in_ready = !(r_out_valid && w_last);
  assign w_accept   = in_valid && w_in_ready;
  assign w_sum      = SUM_W'(r_acc) + SUM_W'(in_data);
  assign w_carry    = |w_sum[SUM_W-1:ACC_WIDTH];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        if (w_carry) begin
          r_overflow <= 1'b1;
        end
        if (w_last) begin
          r_out_data  <= ACC_WIDTH'(w_sum);
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_cnt       <= '0;
        end else begin
          r_acc <= ACC_WIDTH'(w_sum);
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Self-checking bench: scenario tasks plus randomized traffic against a queue-based
// model; extra instances cover an undersized accumulator and LENGTH=1.
module tb_dot_product_accumulator;

  localparam int unsigned W   = 11;
  localparam int unsigned L   = 8;
  localparam int unsigned A   = 14;
  localparam int unsigned A_S = 11;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  // main instance
  logic          in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready, out_valid, overflow;
  logic [A-1:0]  out_data;

  // undersized accumulator instance
  logic           s_in_valid = 1'b0, s_out_ready = 1'b0;
  logic [W-1:0]   s_in_data = '0;
  logic           s_in_ready, s_out_valid, s_overflow;
  logic [A_S-1:0] s_out_data;

  // LENGTH=1 instance
  logic           u_in_valid = 1'b0, u_out_ready = 1'b0;
  logic [W-1:0]   u_in_data = '0;
  logic           u_in_ready, u_out_valid, u_overflow;
  logic [A_S-1:0] u_out_data;

  dot_product_accumulator #(.WIDTH(W), .LENGTH(L), .ACC_WIDTH(A)) dut (
    .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .overflow(overflow));

  dot_product_accumulator #(.WIDTH(W), .LENGTH(L), .ACC_WIDTH(A_S)) dut_small (
    .Clock(Clock), .Reset(Reset), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .overflow(s_overflow));

  dot_product_accumulator #(.WIDTH(W), .LENGTH(1), .ACC_WIDTH(A_S)) dut_len1 (
    .Clock(Clock), .Reset(Reset), .in_valid(u_in_valid), .in_ready(u_in_ready),
    .in_data(u_in_data), .out_valid(u_out_valid), .out_ready(u_out_ready),
    .out_data(u_out_data), .overflow(u_overflow));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: accepted terms of the open vector, plus the pending result.
  longint unsigned m_terms[$];
  bit              m_out_valid;
  longint unsigned m_out_data;
  bit              m_overflow;

  function automatic bit m_in_ready();
    return !(m_out_valid && (m_terms.size() == L - 1));
  endfunction

  function automatic longint unsigned m_vec_sum();
    longint unsigned s = 0;
    foreach (m_terms[i]) s += m_terms[i];
    return s;
  endfunction

  task automatic model_reset();
    m_terms.delete();
    m_out_valid = 0;
    m_out_data  = 0;
    m_overflow  = 0;
  endtask

  // One clock on the main instance: drive, advance the edge, update the model.
  task automatic step(input bit v, input longint unsigned d, input bit r);
    bit acc_now, cons_now;
    longint unsigned old_s, new_s;
    in_valid  = v;
    in_data   = W'(d);
    out_ready = r;
    acc_now  = v && m_in_ready();
    cons_now = m_out_valid && r;
    @(posedge Clock);
    #1;
    if (cons_now) m_out_valid = 0;
    if (acc_now) begin
      old_s = m_vec_sum();
      new_s = old_s + d;
      if ((new_s >> A) != (old_s >> A)) m_overflow = 1;
      m_terms.push_back(d);
      if (m_terms.size() == L) begin
        m_out_data  = new_s % (64'd1 << A);
        m_out_valid = 1;
        m_terms.delete();
      end
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    in_valid = 0; s_in_valid = 0; u_in_valid = 0;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({in_ready, out_valid, overflow} !== 3'b100 || out_data !== '0) begin
      $display("FAIL reset_state: got rdy=%0b vld=%0b ovf=%0b data=%0d, expected 1 0 0 0",
               in_ready, out_valid, overflow, out_data);
    end else n_pass++;
  endtask

  task automatic test_single_vector();
    bit rdy_ok = 1;
    for (int i = 1; i <= 8; i++) begin
      step(1, longint'(i), 1);
      if (in_ready !== 1'b1) rdy_ok = 0;
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== A'(36) || longint'(out_data) != m_out_data) begin
      $display("FAIL single_result: got vld=%0b data=%0d, expected 1 36", out_valid, out_data);
    end else n_pass++;
    n_checks++;
    if (!rdy_ok || overflow !== 1'b0) begin
      $display("FAIL single_ready_ovf: got rdy_ok=%0b ovf=%0b, expected 1 0", rdy_ok, overflow);
    end else n_pass++;
    step(0, 0, 1);
    n_checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL single_pulse: got vld=%0b, expected 0", out_valid);
    end else n_pass++;
  endtask

  task automatic test_max_values();
    for (int i = 0; i < 8; i++) step(1, 2047, 1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== A'(16376) || overflow !== 1'b0) begin
      $display("FAIL max_values: got vld=%0b data=%0d ovf=%0b, expected 1 16376 0",
               out_valid, out_data, overflow);
    end else n_pass++;
    step(0, 0, 1);
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) step(1, 5, 0);
    for (int i = 0; i < 7; i++) step(1, 5, 0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== A'(40) || in_ready !== 1'b0) begin
      $display("FAIL bp_held: got vld=%0b data=%0d rdy=%0b, expected 1 40 0",
               out_valid, out_data, in_ready);
    end else n_pass++;
    step(1, 5, 1);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL bp_consume: got vld=%0b rdy=%0b, expected 0 1", out_valid, in_ready);
    end else n_pass++;
    step(1, 5, 0);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== A'(40) || longint'(out_data) != m_out_data) begin
      $display("FAIL bp_second: got vld=%0b data=%0d, expected 1 40", out_valid, out_data);
    end else n_pass++;
    step(0, 0, 1);
  endtask

  task automatic test_bubbles();
    int seq[11] = '{3, 0, -1, -1, 7, 1, -1, 2, 2, 2, 2};
    int n_results = 0;
    foreach (seq[i]) begin
      if (seq[i] < 0) step(0, longint'($urandom_range(0, 2047)), 1);
      else            step(1, longint'(seq[i]), 1);
      if (out_valid === 1'b1) n_results++;
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== A'(19) || n_results != 1) begin
      $display("FAIL bubbles: got vld=%0b data=%0d results=%0d, expected 1 19 1",
               out_valid, out_data, n_results);
    end else n_pass++;
    step(0, 0, 1);
  endtask

  task automatic test_reset_mid_vector();
    for (int i = 0; i < 3; i++) step(1, 9, 1);
    do_reset();
    n_checks++;
    if ({in_ready, out_valid, overflow} !== 3'b100 || out_data !== '0) begin
      $display("FAIL mid_reset_state: got rdy=%0b vld=%0b ovf=%0b data=%0d, expected 1 0 0 0",
               in_ready, out_valid, overflow, out_data);
    end else n_pass++;
    for (int i = 0; i < 8; i++) step(1, 1, 1);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== A'(8)) begin
      $display("FAIL mid_reset_result: got vld=%0b data=%0d, expected 1 8", out_valid, out_data);
    end else n_pass++;
    step(0, 0, 1);
  endtask

  task automatic test_undersized();
    bit ovf_ok = 1;
    for (int i = 0; i < 8; i++) begin
      s_in_valid = 1; s_in_data = W'(2047); s_out_ready = 0;
      @(posedge Clock);
      #1;
      if (s_overflow !== (i >= 1)) ovf_ok = 0;
    end
    s_in_valid = 0;
    n_checks++;
    if (!ovf_ok) $display("FAIL small_ovf_timing: got mismatched sticky flag, expected rise on 2nd accept");
    else n_pass++;
    n_checks++;
    if (s_out_valid !== 1'b1 || s_out_data !== A_S'(2040) || s_overflow !== 1'b1) begin
      $display("FAIL small_result: got vld=%0b data=%0d ovf=%0b, expected 1 2040 1",
               s_out_valid, s_out_data, s_overflow);
    end else n_pass++;
    s_out_ready = 1;
    @(posedge Clock);
    #1;
    s_out_ready = 0;
    n_checks++;
    if (s_overflow !== 1'b1 || s_out_valid !== 1'b0) begin
      $display("FAIL small_sticky: got ovf=%0b vld=%0b, expected 1 0", s_overflow, s_out_valid);
    end else n_pass++;
    do_reset();
    n_checks++;
    if (s_overflow !== 1'b0) $display("FAIL small_ovf_reset: got %0b, expected 0", s_overflow);
    else n_pass++;
  endtask

  task automatic test_length_one();
    u_in_valid = 1; u_in_data = W'(5); u_out_ready = 0;
    @(posedge Clock);
    #1;
    u_in_data = W'(9);
    n_checks++;
    if (u_out_valid !== 1'b1 || u_out_data !== A_S'(5) || u_in_ready !== 1'b0) begin
      $display("FAIL len1_first: got vld=%0b data=%0d rdy=%0b, expected 1 5 0",
               u_out_valid, u_out_data, u_in_ready);
    end else n_pass++;
    u_out_ready = 1;
    @(posedge Clock);
    #1;
    u_out_ready = 0;
    n_checks++;
    if (u_out_valid !== 1'b0 || u_in_ready !== 1'b1) begin
      $display("FAIL len1_consume: got vld=%0b rdy=%0b, expected 0 1", u_out_valid, u_in_ready);
    end else n_pass++;
    @(posedge Clock);
    #1;
    u_in_valid = 0;
    n_checks++;
    if (u_out_valid !== 1'b1 || u_out_data !== A_S'(9)) begin
      $display("FAIL len1_second: got vld=%0b data=%0d, expected 1 9", u_out_valid, u_out_data);
    end else n_pass++;
  endtask

  task automatic test_random();
    int bad = 0;
    int first_bad_cycle = -1;
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 3) != 0, longint'($urandom_range(0, 2047)), $urandom_range(0, 2) != 0);
      if (in_ready !== m_in_ready() || out_valid !== m_out_valid || overflow !== m_overflow ||
          (m_out_valid && longint'(out_data) != m_out_data)) begin
        if (bad == 0) begin
          first_bad_cycle = c;
          $display("FAIL random_cycle: at cycle %0d got rdy=%0b vld=%0b data=%0d ovf=%0b, expected %0b %0b %0d %0b",
                   c, in_ready, out_valid, out_data, overflow,
                   m_in_ready(), m_out_valid, m_out_data, m_overflow);
        end
        bad++;
      end
    end
    n_checks++;
    if (bad != 0) $display("FAIL random_total: got %0d bad cycles (first %0d), expected 0", bad, first_bad_cycle);
    else n_pass++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_vector();
    test_max_values();
    test_backpressure();
    test_bubbles();
    test_reset_mid_vector();
    test_undersized();
    test_length_one();
    do_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
